// File: rtl/fxp_pkg.sv
// Shared fixed-point package: default operand format, FSM state type and
// counter-width helper. Also imported by the sqrt unit.
package fxp_pkg;

    localparam int FXP_INT_W  = 8;
    localparam int FXP_FRAC_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } fxp_state_e;

    // Ceiling log2; used as clog2(W+1) to size a counter that reaches W.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/fxp_narrow_sat.sv
// Combinational Q(2I).(2F) -> Q(I).(F) narrowing with saturation.
// Build option FXP_SQUARE_ROUND_EN: round half-up instead of truncating.
module fxp_narrow_sat
    import fxp_pkg::*;
#(
    parameter int INTEGER_WIDTH  = FXP_INT_W,
    parameter int FRACTION_WIDTH = FXP_FRAC_W,
    localparam int W = INTEGER_WIDTH + FRACTION_WIDTH
) (
    input  logic [2*W-1:0] full,
    output logic [W-1:0]   narrow,
    output logic           ovf
);

    localparam int F = FRACTION_WIDTH;

    logic [W-1:0] cand;
    logic         hi_nz;
    logic [W:0]   rnd;

    assign cand  = full[W+F-1:F];
    assign hi_nz = |full[2*W-1:W+F];

    // Select truncated or rounded candidate; any lost integer bit saturates.
    always_comb begin
`ifdef FXP_SQUARE_ROUND_EN
        rnd = {1'b0, cand} + {{W{1'b0}}, full[F-1]};
        ovf = hi_nz | rnd[W];
        narrow = ovf ? {W{1'b1}} : rnd[W-1:0];
`else
        rnd = {1'b0, cand};
        ovf = hi_nz;
        narrow = ovf ? {W{1'b1}} : cand;
`endif
    end

endmodule

// File: rtl/fixed_point_square_seq.sv
// Iterative unsigned fixed-point squarer: one shift-add step per clock,
// W steps per operand, exact 2W-bit square plus saturated Q(I).(F) copy.
// Build option FXP_SQUARE_ROUND_EN selects round-half-up narrowing.
module fixed_point_square_seq
    import fxp_pkg::*;
#(
    parameter int INTEGER_WIDTH  = FXP_INT_W,
    parameter int FRACTION_WIDTH = FXP_FRAC_W,
    localparam int W = INTEGER_WIDTH + FRACTION_WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   num,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] sq,
    output logic [W-1:0]   sq_q,
    output logic           ovf
);

    localparam int CW = clog2(W + 1);

    fxp_state_e     state_q, state_d;
    logic [W-1:0]   mcand_q, mcand_d;
    logic [W-1:0]   mplier_q, mplier_d;
    logic [2*W-1:0] acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*W-1:0] res_sq_q, res_sq_d;
    logic [W-1:0]   res_nar_q, res_nar_d;
    logic           res_ovf_q, res_ovf_d;

    logic [2*W-1:0] addend;
    logic [2*W-1:0] acc_sum;
    logic [W-1:0]   nar;
    logic           nar_ovf;

    // Partial product for this step and the running sum it produces.
    assign addend  = mplier_q[0] ? ({{W{1'b0}}, mcand_q} << cnt_q) : '0;
    assign acc_sum = acc_q + addend;

    // Narrow the sum as it stands on the last step so results load directly.
    fxp_narrow_sat #(
        .INTEGER_WIDTH (INTEGER_WIDTH),
        .FRACTION_WIDTH(FRACTION_WIDTH)
    ) u_narrow (
        .full  (acc_sum),
        .narrow(nar),
        .ovf   (nar_ovf)
    );

    // Next-state and datapath control.
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        res_sq_d  = res_sq_q;
        res_nar_d = res_nar_q;
        res_ovf_d = res_ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d  = num;
                    mplier_d = num;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                acc_d    = acc_sum;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    res_sq_d  = acc_sum;
                    res_nar_d = nar;
                    res_ovf_d = nar_ovf;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            res_sq_q  <= '0;
            res_nar_q <= '0;
            res_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            res_sq_q  <= res_sq_d;
            res_nar_q <= res_nar_d;
            res_ovf_q <= res_ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sq        = res_sq_q;
    assign sq_q      = res_nar_q;
    assign ovf       = res_ovf_q;

endmodule

// File: tb/tb_fixed_point_square_seq.sv
// Scoreboard bench for fixed_point_square_seq: stimulus pushes hand-computed
// results, a negedge monitor pops and checks them, plus reset, latency,
// hold-stability and accept-spacing checks.
module tb_fixed_point_square_seq;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  num = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [2*W-1:0] sq;
    logic [W-1:0]  sq_q;
    logic          ovf;

    typedef struct {
        logic [31:0] sq;
        logic [15:0] q;
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];

    int  n_cmp = 0;
    int  n_bad = 0;
    int  timeouts = 0;
    bit  done = 1'b0;
    bit  b2b = 1'b0;

`ifdef FXP_SQUARE_ROUND_EN
    localparam logic [15:0] Q_000C = 16'h0001;
`else
    localparam logic [15:0] Q_000C = 16'h0000;
`endif

    fixed_point_square_seq dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .num      (num),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sq       (sq),
        .sq_q     (sq_q),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Present one operand until accepted; its expected result goes on the queue.
    task automatic send(input logic [15:0] n, input logic [31:0] e_sq,
                        input logic [15:0] e_q, input logic e_ovf);
        exp_t e;
        bit   ok;
        e.sq = e_sq; e.q = e_q; e.ovf = e_ovf;
        exp_q.push_back(e);
        num = n;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1 && !rst) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeouts++;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && out_valid === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeouts++;
        @(posedge clk);
        #1;
    endtask

    // Stimulus.
    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;

        send(16'h3039, 32'h09156CB1, 16'hFFFF, 1'b1);
        drain();

        send(16'h0180, 32'h00024000, 16'h0240, 1'b0);
        send(16'h0100, 32'h00010000, 16'h0100, 1'b0);
        send(16'h000C, 32'h00000090, Q_000C,   1'b0);
        send(16'h0000, 32'h00000000, 16'h0000, 1'b0);
        send(16'hFFFF, 32'hFFFE0001, 16'hFFFF, 1'b1);
        drain();

        // Backpressure with a spurious operand offered while the result is held.
        out_ready = 1'b0;
        send(16'h2694, 32'h05D04590, 16'hFFFF, 1'b1);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) break;
        end
        @(posedge clk);
        #1 num = 16'h1111;
        in_valid = 1'b1;
        repeat (4) @(posedge clk);
        #1 in_valid = 1'b0;
        out_ready = 1'b1;
        drain();

        // Reset in the middle of a calculation discards the operand.
        send(16'h3039, 32'h09156CB1, 16'hFFFF, 1'b1);
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        send(16'h0180, 32'h00024000, 16'h0240, 1'b0);
        drain();

        // Back-to-back operands.
        b2b = 1'b1;
        send(16'h0180, 32'h00024000, 16'h0240, 1'b0);
        send(16'h2694, 32'h05D04590, 16'hFFFF, 1'b1);
        drain();
        b2b = 1'b0;

        done = 1'b1;
    end

    // Monitor / scoreboard.
    initial begin
        int   cyc;
        int   acc_cyc;
        bit   have_acc;
        int   b2b_n;
        bit   rst_pend;
        bit   ov_prev;
        exp_t e;
        logic [31:0] h_sq;
        logic [15:0] h_q;
        logic        h_ovf;
        cyc = 0; acc_cyc = 0; have_acc = 1'b0; b2b_n = 0;
        rst_pend = 1'b0; ov_prev = 1'b0;
        h_sq = '0; h_q = '0; h_ovf = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_pend) begin
                chk("rst_in_ready",  32'(in_ready),  32'd1);
                chk("rst_out_valid", 32'(out_valid), 32'd0);
                chk("rst_sq",        sq,             32'd0);
                chk("rst_sq_q",      32'(sq_q),      32'd0);
                chk("rst_ovf",       32'(ovf),       32'd0);
            end
            rst_pend = rst;
            if (!b2b) b2b_n = 0;
            if (rst) begin
                ov_prev  = 1'b0;
                have_acc = 1'b0;
            end else begin
                if (in_valid && in_ready) begin
                    if (b2b && b2b_n > 0) chk("accept_spacing", 32'(cyc - acc_cyc), 32'(W + 2));
                    if (b2b) b2b_n++;
                    acc_cyc  = cyc;
                    have_acc = 1'b1;
                end
                if (out_valid === 1'b1) begin
                    if (!ov_prev) begin
                        if (have_acc) chk("latency", 32'(cyc - acc_cyc), 32'(W + 1));
                        h_sq = sq; h_q = sq_q; h_ovf = ovf;
                    end else begin
                        chk("hold_sq",   sq,         h_sq);
                        chk("hold_sq_q", 32'(sq_q),  32'(h_q));
                        chk("hold_ovf",  32'(ovf),   32'(h_ovf));
                    end
                    chk("busy_in_ready", 32'(in_ready), 32'd0);
                    if (out_ready) begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected_result", 32'd1, 32'd0);
                        end else begin
                            e = exp_q.pop_front();
                            chk("sq",   sq,        e.sq);
                            chk("sq_q", 32'(sq_q), 32'(e.q));
                            chk("ovf",  32'(ovf),  32'(e.ovf));
                        end
                    end
                    ov_prev = !out_ready;
                end else begin
                    ov_prev = 1'b0;
                end
            end
            if (done || cyc > 5000) begin
                chk("watchdog",     32'(cyc > 5000),    32'd0);
                chk("timeouts",     32'(timeouts),      32'd0);
                chk("queue_drained", 32'(exp_q.size()), 32'd0);
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
                $finish;
            end
        end
    end

endmodule

// File: doc/fixed_point_square_seq.md
Name: fixed_point_square_seq

Overview:
- Iterative unsigned fixed-point squarer, the inverse operation of the square-root unit, on the same operand format.
- Accepts a Q(INTEGER_WIDTH).(FRACTION_WIDTH) operand over a valid/ready handshake.
- Computes the exact square in Q(2*INTEGER_WIDTH).(2*FRACTION_WIDTH), one shift-add step per clock, plus a narrowed Q(I).(F) copy with overflow flag.
- Sits after the sqrt unit in the arithmetic datapath, so sqrt results can be squared back for self-check and for reuse.

Parameters:
- INTEGER_WIDTH, 8, integer bits of the operand.
- FRACTION_WIDTH, 8, fraction bits of the operand; W = INTEGER_WIDTH+FRACTION_WIDTH.

Ports:
- clk  in  1  single clock, all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand valid.
- in_ready  out  1  block can accept an operand.
- num  in  W  unsigned Q(I).(F) operand.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- sq  out  2W  exact square, unsigned Q(2I).(2F).
- sq_q  out  W  square narrowed to Q(I).(F), saturating.
- ovf  out  1  sq_q saturated.

Behaviour:
- Reset (rst=1 at an edge, from any state, including mid-calculation): state IDLE, in_ready=1, out_valid=0, sq=0, sq_q=0, ovf=0, internal accumulator/counter cleared. Any in-flight operand is discarded.
- FSM states: IDLE, CALC, DONE.
- IDLE: in_ready=1.
  - On in_valid&in_ready at edge k: latch num into multiplicand and multiplier registers, clear the 2W accumulator, set the bit counter to 0, go to CALC.
- CALC: in_ready=0. Each edge performs one step:
  - If multiplier LSB=1, add (multiplicand << count) to the accumulator.
  - Shift the multiplier right by 1 and increment the counter.
  - After W steps (edges k+1..k+W), load sq, sq_q and ovf from the final sum and enter DONE on edge k+W.
  - Latency from accept edge to out_valid high is exactly W cycles (16 at defaults).
- DONE: out_valid=1, in_ready=0.
  - sq, sq_q and ovf stay stable until out_valid&out_ready is sampled at an edge, then go to IDLE.
  - No new operand is accepted in the same cycle as output consumption; the next accept can occur one cycle later. Max throughput is one result per W+2 cycles.
- in_valid is ignored outside IDLE. num is only sampled on the accept edge.
- Arithmetic:
  - The accumulator is 2W bits and never overflows, since (2^W-1)^2 < 2^(2W).
  - sq = num*num, interpreted with 2F fraction bits.
- Narrowing: the candidate is sq[W+F-1:F], i.e. drop F LSBs and keep I integer and F fraction bits.
  - ovf=1 when sq[2W-1:W+F] is nonzero (or on rounding carry, see the optional feature).
  - When ovf=1, sq_q = all ones (2^W-1). Otherwise sq_q = the candidate.
- Operand 0 gives sq=0, sq_q=0, ovf=0 with the same W-cycle latency. Latency is data-independent.

Optional Feature:
- Macro: FXP_SQUARE_ROUND_EN.
- Defined: sq_q rounds half-up.
  - candidate + sq[F-1] is computed in W+1 bits.
  - A carry out, or a nonzero sq[2W-1:W+F], sets ovf and saturates sq_q to all ones.
- Undefined: sq_q truncates (sq[F-1:0] discarded).
- sq, latency and handshake are identical in both builds.

Decomposition:
- Shared package fxp_pkg:
  - default INTEGER_WIDTH/FRACTION_WIDTH constants;
  - FSM state typedef (IDLE/CALC/DONE);
  - counter width function clog2(W+1).
  - The same package is used by the sqrt unit.
- One natural sub-module: fxp_narrow_sat, combinational 2W to W narrowing with saturation (and rounding under the macro). It is reused later for the multiplier.
- The FSM and shift-add datapath stay in the top module.

Test Plan:
- num=0x3039 (48.22), out_ready=1 -> after 16 cycles sq=0x09156CB1, ovf=1, sq_q=0xFFFF.
- num=0x0180 (1.5) -> sq=0x00024000, sq_q=0x0240, ovf=0. num=0x0100 -> sq=0x00010000, sq_q=0x0100.
- num=0x000C -> sq=0x00000090, sq_q=0x0000 without FXP_SQUARE_ROUND_EN and 0x0001 with it. num=0xFFFF -> sq=0xFFFE0001, ovf=1.
- Backpressure: num=0x2694, out_ready=0 for 5 cycles after out_valid -> sq=0x05D04590 held stable, in_ready=0 throughout, a second in_valid is ignored; result consumed on the first out_ready=1 edge.
- rst pulsed at CALC step 7 of num=0x3039 -> next cycle in_ready=1, out_valid=0, sq=0. A following num=0x0180 completes correctly in 16 cycles.
- Back-to-back: two operands presented continuously -> accepts are spaced W+2=18 cycles apart, results appear in order, no lost or duplicated result.
